// File: rtl/gpio_debounce_pio_pkg.sv
// Shared constants for the debounced switch / LED PIO: register map and bus width.
package gpio_debounce_pio_pkg;
    localparam int         DATA_W       = 32;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_LED     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;
endpackage

// File: rtl/gpio_debounce_pio_sw_debounce.sv
// One switch channel: 2-flop synchroniser, stability counter and accepted (stable) level.
module sw_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic stable
);
    localparam int CW = $clog2(DB_CYCLES);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    // Any return to the stable level clears the count, so glitches never accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/gpio_debounce_pio.sv
// Debounced switch inputs and LED outputs behind a 4-word Avalon-MM slave.
// Define GPIO_DEBOUNCE_PIO_IRQ_EN to build the IRQMASK/EDGECAP registers and irq.
module gpio_debounce_pio
    import gpio_debounce_pio_pkg::*;
#(
    parameter int               N_SW        = 2,
    parameter int               N_LED       = 2,
    parameter int               DB_CYCLES   = 500000,
    parameter logic [N_LED-1:0] MIRROR_MASK = N_LED'(1)
) (
    input  logic              MAX10_CLK1_50,
    input  logic              reset_reset_n,
    input  logic [N_SW-1:0]   sw_in,
    output logic [N_LED-1:0]  led_out,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              irq
);
    logic [N_SW-1:0]   stable;
    logic [N_LED-1:0]  led_reg;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_wdata;

    assign unused_wdata = ^avs_writedata;

    for (genvar g = 0; g < N_SW; g++) begin : g_ch
        sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (MAX10_CLK1_50),
            .rst_n  (reset_reset_n),
            .sw     (sw_in[g]),
            .stable (stable[g])
        );
    end

    // Mirrored LEDs are active-low copies of the switch, so they sit at 1 in reset.
    for (genvar g = 0; g < N_LED; g++) begin : g_led
        if (g < N_SW && MIRROR_MASK[g]) begin : g_mir
            assign led_out[g] = ~stable[g];
        end else begin : g_reg
            assign led_out[g] = led_reg[g];
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led_reg <= '0;
        end else if (avs_write && avs_address == ADDR_LED) begin
            led_reg <= avs_writedata[N_LED-1:0];
        end
    end

`ifdef GPIO_DEBOUNCE_PIO_IRQ_EN
    logic [N_SW-1:0] irq_mask, edge_cap, stable_d, rise, ec_clr;

    assign rise   = stable & ~stable_d;
    assign ec_clr = (avs_write && avs_address == ADDR_EDGECAP) ? avs_writedata[N_SW-1:0] : '0;

    // Set wins over a coincident W1C so an edge is never lost.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
            stable_d <= '0;
            irq      <= 1'b0;
        end else begin
            stable_d <= stable;
            if (avs_write && avs_address == ADDR_IRQMASK)
                irq_mask <= avs_writedata[N_SW-1:0];
            edge_cap <= (edge_cap & ~ec_clr) | rise;
            irq      <= |(edge_cap & irq_mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA:    rd_mux = DATA_W'(stable);
            ADDR_LED:     rd_mux = DATA_W'(led_reg);
`ifdef GPIO_DEBOUNCE_PIO_IRQ_EN
            ADDR_IRQMASK: rd_mux = DATA_W'(irq_mask);
            ADDR_EDGECAP: rd_mux = DATA_W'(edge_cap);
`endif
            default:      rd_mux = '0;
        endcase
    end

    // A write alongside a read suppresses the read; readdata keeps its last value.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read && !avs_write) begin
            avs_readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_gpio_debounce_pio.sv
// Scoreboarded bench for gpio_debounce_pio with DB_CYCLES=8, two switches, LED0 mirrored.
module tb_gpio_debounce_pio;
    import gpio_debounce_pio_pkg::*;

`ifdef GPIO_DEBOUNCE_PIO_IRQ_EN
    localparam logic [31:0] IRQ_EN = 32'd1;
`else
    localparam logic [31:0] IRQ_EN = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sw_in;
    logic [1:0]  led_out;
    logic [1:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        irq;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        rd_fire = 1'b0;

    always #5 clk = ~clk;

    gpio_debounce_pio #(
        .N_SW(2), .N_LED(2), .DB_CYCLES(8), .MIRROR_MASK(2'b01)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .reset_reset_n (rst_n),
        .sw_in         (sw_in),
        .led_out       (led_out),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Read scoreboard: a read accepted on an edge is compared at the following negedge.
    always @(posedge clk) rd_fire <= avs_read && !avs_write && rst_n;
    always @(negedge clk) begin
        if (rd_fire) begin
            if (exp_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
            else                   chk("readdata", avs_readdata, exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick(1);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e);
        avs_address = a; avs_read = 1'b1;
        exp_q.push_back(e);
        tick(1);
        avs_read = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sw_in = '0; avs_address = '0;
        avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        tick(3);
        chk("rst_led", 32'(led_out), 32'h1);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Short glitch on sw1 is rejected
        sw_in[1] = 1'b1; tick(5); sw_in[1] = 1'b0; tick(12);
        rd(ADDR_DATA, 32'h0);
        rd(ADDR_EDGECAP, 32'h0);

        // Held edge on sw0 lands exactly 10 cycles later
        sw_in[0] = 1'b1;
        tick(9);
        chk("db_pre_led", 32'(led_out), 32'h1);
        tick(1);
        chk("db_led", 32'(led_out), 32'h0);
        rd(ADDR_DATA, 32'h1);
        rd(ADDR_EDGECAP, IRQ_EN);
        chk("irq_masked", 32'(irq), 32'h0);
        wr(ADDR_EDGECAP, 32'h1);
        rd(ADDR_EDGECAP, 32'h0);

        // LED register, read-only DATA, upper bits
        wr(ADDR_LED, 32'h2);
        rd(ADDR_LED, 32'h2);
        chk("led_reg", 32'(led_out), 32'h2);
        wr(ADDR_DATA, 32'hFFFF_FFFF);
        rd(ADDR_DATA, 32'h1);
        wr(ADDR_LED, 32'hFFFF_FFFF);
        rd(ADDR_LED, 32'h3);
        wr(ADDR_LED, 32'h2);
        rd(ADDR_IRQMASK, 32'h0);

        // Interrupt on a masked rising edge, then W1C
        wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
        rd(ADDR_IRQMASK, IRQ_EN ? 32'h3 : 32'h0);
        wr(ADDR_IRQMASK, 32'h1);
        sw_in[0] = 1'b0; tick(12);
        sw_in[0] = 1'b1;
        tick(11);
        chk("irq_pre", 32'(irq), 32'h0);
        tick(1);
        chk("irq_set", 32'(irq), IRQ_EN);
        rd(ADDR_EDGECAP, IRQ_EN);
        wr(ADDR_EDGECAP, 32'h1);
        tick(1);
        chk("irq_clr", 32'(irq), 32'h0);
        rd(ADDR_EDGECAP, 32'h0);

        // W1C on the same edge as a new capture: set wins
        sw_in[0] = 1'b0; tick(12);
        sw_in[0] = 1'b1;
        tick(10);
        wr(ADDR_EDGECAP, 32'h1);
        rd(ADDR_EDGECAP, IRQ_EN);
        chk("irq_coinc", 32'(irq), IRQ_EN);

        // Simultaneous read and write: write applies, readdata holds
        avs_address = ADDR_LED; avs_writedata = 32'h0;
        avs_read = 1'b1; avs_write = 1'b1;
        tick(1);
        avs_read = 1'b0; avs_write = 1'b0;
        chk("rdwr_hold", avs_readdata, IRQ_EN);
        chk("rdwr_led", 32'(led_out), 32'h0);
        wr(ADDR_LED, 32'h2);
        wr(ADDR_EDGECAP, 32'h3);

        // Reset mid-count with sw0 held high
        sw_in[0] = 1'b0; tick(12);
        rd(ADDR_LED, 32'h2);
        sw_in[0] = 1'b1;
        tick(7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_led", 32'(led_out), 32'h1);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_rdata", avs_readdata, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(9);
        chk("rel_pre_led", 32'(led_out), 32'h1);
        tick(1);
        chk("rel_led", 32'(led_out), 32'h0);
        rd(ADDR_DATA, 32'h1);
        rd(ADDR_LED, 32'h0);
        rd(ADDR_EDGECAP, IRQ_EN);
        rd(ADDR_IRQMASK, 32'h0);
        chk("rel_irq", 32'(irq), 32'h0);

        tick(3);
        chk("rd_drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
